// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator: command/state types
// and the note-to-Hz table consumed by note2freq.
package synth_pkg;
   localparam int NUM_OSC = 64;
   localparam int OSC_W   = 6;
   localparam int STAMP_W = 16;

   typedef enum logic [7:0] {SAW = 8'd0, SQUARE = 8'd1, TRI = 8'd2, SINE = 8'd3} wave_e;

   typedef struct packed {
      logic       on;
      logic [6:0] note;
      logic [7:0] wav;
   } cmd_t;

   typedef enum logic [2:0] {INIT, IDLE, SCAN, DECIDE, WRITE} state_e;

   // Top octave (notes 116..127) held in milli-Hz; every lower note is that
   // value divided by a power of two and rounded to the nearest Hz.
   function automatic logic [127:0][23:0] build_note_hz();
      longint            top_mhz [12];
      logic [127:0][23:0] t;
      int                d;
      longint            div;
      top_mhz = '{6644875, 7040000, 7458620, 7902133, 8372018, 8869844,
                  9397273, 9956063, 10548082, 11175303, 11839822, 12543854};
      t = '0;
      for (int n = 0; n < 128; n++) begin
         d    = 10 - (n + 4) / 12;
         div  = longint'(1000) << d;
         t[n] = 24'((top_mhz[(n + 4) % 12] + div / 2) / div);
      end
      return t;
   endfunction

   localparam logic [127:0][23:0] NOTE_HZ = build_note_hz();
endpackage

// File: rtl/note2freq.sv
// Registered 128x24 note-to-Hz ROM, one cycle latency; holds its output
// while en is low so the value loaded at accept survives the scan.
module note2freq
   import synth_pkg::*;
(
   input  logic        i_clk48,
   input  logic        en,
   input  logic [6:0]  note,
   output logic [23:0] hz
);
   always_ff @(posedge i_clk48)
      if (en) hz <= NOTE_HZ[note];
endmodule

// File: rtl/voice_alloc.sv
// 64-slot voice allocator driving the oscillator write interface.
// Optional VOICE_STEAL_EN: a note-on with a full table steals the oldest voice.
module voice_alloc
   import synth_pkg::*;
(
   input  logic               i_clk48,
   input  logic               i_rst48_n,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic               i_cmd_on,
   input  logic [6:0]         i_cmd_note,
   input  logic [7:0]         i_cmd_wav,
   output logic [OSC_W-1:0]   o_osc_sel,
   output logic [23:0]        o_t_freq,
   output logic               o_tf_valid,
   output logic [7:0]         o_wav_sel,
   output logic               o_ws_valid,
   output logic [NUM_OSC-1:0] o_active,
   output logic               o_drop
);
   state_e                  state;
   cmd_t                    cmd;
   logic [1:0]              ph;
   logic [OSC_W-1:0]        idx;
   logic [7:0]              wr_wav;
   logic [23:0]             wr_freq;
   logic [NUM_OSC-1:0]      tab_valid;
   logic [NUM_OSC-1:0][6:0] tab_note;
   logic [NUM_OSC-1:0][7:0] tab_wav;
   logic                    m_found, f_found;
   logic [OSC_W-1:0]        m_idx, f_idx;
   logic [23:0]             rom_hz;
   logic                    accept;
   logic                    do_wr;
   logic [OSC_W-1:0]        tgt;
`ifdef VOICE_STEAL_EN
   logic [NUM_OSC-1:0][STAMP_W-1:0] tab_stamp;
   logic [STAMP_W-1:0]              stamp_now, o_age, age;
   logic                            o_found;
   logic [OSC_W-1:0]                o_idx;

   // Age in allocations, valid across stamp wrap.
   assign age = stamp_now - tab_stamp[idx];
`endif

   assign accept   = i_cmd_valid && o_cmd_ready;
   assign o_active = tab_valid;

   note2freq u_rom (.i_clk48(i_clk48), .en(accept), .note(i_cmd_note), .hz(rom_hz));

   always_comb begin
      do_wr = 1'b0;
      tgt   = m_idx;
      if (m_found) do_wr = 1'b1;
      else if (cmd.on && f_found) begin
         do_wr = 1'b1;
         tgt   = f_idx;
      end
`ifdef VOICE_STEAL_EN
      else if (cmd.on) begin
         do_wr = 1'b1;
         tgt   = o_idx;
      end
`endif
   end

   always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
      if (!i_rst48_n) begin
         state       <= INIT;
         cmd         <= '0;
         ph          <= '0;
         idx         <= '0;
         wr_wav      <= '0;
         wr_freq     <= '0;
         tab_valid   <= '0;
         tab_note    <= '0;
         tab_wav     <= '0;
         m_found     <= 1'b0;
         f_found     <= 1'b0;
         m_idx       <= '0;
         f_idx       <= '0;
         o_cmd_ready <= 1'b0;
         o_osc_sel   <= '0;
         o_t_freq    <= '0;
         o_tf_valid  <= 1'b0;
         o_wav_sel   <= '0;
         o_ws_valid  <= 1'b0;
         o_drop      <= 1'b0;
`ifdef VOICE_STEAL_EN
         tab_stamp   <= '0;
         stamp_now   <= '0;
         o_age       <= '0;
         o_found     <= 1'b0;
         o_idx       <= '0;
`endif
      end else begin
         o_drop <= 1'b0;
         case (state)
            // INIT walks o_osc_sel over every slot; WRITE runs a single triplet.
            INIT, WRITE: begin
               case (ph)
                  2'd0: begin
                     o_ws_valid <= 1'b1;
                     o_wav_sel  <= wr_wav;
                     ph         <= 2'd1;
                  end
                  2'd1: begin
                     o_ws_valid <= 1'b0;
                     o_tf_valid <= 1'b1;
                     o_t_freq   <= wr_freq;
                     ph         <= 2'd2;
                  end
                  default: begin
                     o_tf_valid <= 1'b0;
                     ph         <= 2'd0;
                     if (state == WRITE || o_osc_sel == OSC_W'(NUM_OSC - 1)) begin
                        state       <= IDLE;
                        o_cmd_ready <= 1'b1;
                     end else
                        o_osc_sel <= o_osc_sel + 1'b1;
                  end
               endcase
            end
            IDLE: begin
               if (accept) begin
                  cmd         <= '{on: i_cmd_on, note: i_cmd_note, wav: i_cmd_wav};
                  o_cmd_ready <= 1'b0;
                  m_found     <= 1'b0;
                  f_found     <= 1'b0;
                  idx         <= '0;
`ifdef VOICE_STEAL_EN
                  o_found     <= 1'b0;
`endif
                  state       <= SCAN;
               end
            end
            SCAN: begin
               if (!m_found && tab_valid[idx] && tab_note[idx] == cmd.note) begin
                  m_found <= 1'b1;
                  m_idx   <= idx;
               end
               if (!f_found && !tab_valid[idx]) begin
                  f_found <= 1'b1;
                  f_idx   <= idx;
               end
`ifdef VOICE_STEAL_EN
               if (tab_valid[idx] && (!o_found || age > o_age)) begin
                  o_found <= 1'b1;
                  o_idx   <= idx;
                  o_age   <= age;
               end
`endif
               idx <= idx + 1'b1;
               if (idx == OSC_W'(NUM_OSC - 1)) state <= DECIDE;
            end
            DECIDE: begin
               if (do_wr) begin
                  o_osc_sel <= tgt;
                  ph        <= 2'd0;
                  state     <= WRITE;
                  if (cmd.on) begin
                     tab_valid[tgt] <= 1'b1;
                     tab_note[tgt]  <= cmd.note;
                     tab_wav[tgt]   <= cmd.wav;
                     wr_wav         <= cmd.wav;
                     wr_freq        <= rom_hz;
`ifdef VOICE_STEAL_EN
                     tab_stamp[tgt] <= stamp_now;
                     stamp_now      <= stamp_now + 1'b1;
`endif
                  end else begin
                     tab_valid[tgt] <= 1'b0;
                     wr_wav         <= tab_wav[tgt];
                     wr_freq        <= '0;
                  end
               end else begin
                  o_drop      <= 1'b1;
                  o_cmd_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: INIT sweep, directed vectors, random traffic against
// a slot/age reference model, full-table and mid-scan reset sequences.
module tb_voice_alloc;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_on = 1'b0;
   logic [6:0]  cmd_note = '0;
   logic [7:0]  cmd_wav = '0;
   logic        cmd_ready, tf_valid, ws_valid, drop;
   logic [5:0]  osc_sel;
   logic [23:0] t_freq;
   logic [7:0]  wav_sel;
   logic [63:0] active;

   always #10 clk = ~clk;

   voice_alloc dut (
      .i_clk48(clk), .i_rst48_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_on(cmd_on), .i_cmd_note(cmd_note), .i_cmd_wav(cmd_wav),
      .o_osc_sel(osc_sel), .o_t_freq(t_freq), .o_tf_valid(tf_valid),
      .o_wav_sel(wav_sel), .o_ws_valid(ws_valid), .o_active(active), .o_drop(drop)
   );

   int errors = 0, checks = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   bit m_valid [64];
   int m_note  [64];
   int m_wav   [64];
   int m_seq   [64];
   int seq_ctr;

   typedef struct {
      bit          wr;
      int          sel, wav, freq;
      bit          drop;
      logic [63:0] active;
   } exp_t;

   function automatic int hz(input int n);
      real f;
      f = 440.0 * (2.0 ** ((n - 69) / 12.0));
      return $rtoi(f + 0.5);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0; m_note[i] = 0; m_wav[i] = 0; m_seq[i] = 0;
      end
      seq_ctr = 0;
   endtask

   task automatic model_cmd(input bit on, input int note, input int wav, output exp_t e);
      int slot, best;
      e = '{default: 0};
      slot = -1;
      for (int i = 0; i < 64; i++)
         if (slot < 0 && m_valid[i] && m_note[i] == note) slot = i;
      if (on && slot < 0)
         for (int i = 0; i < 64; i++)
            if (slot < 0 && !m_valid[i]) slot = i;
`ifdef VOICE_STEAL_EN
      if (on && slot < 0) begin
         best = -1;
         for (int i = 0; i < 64; i++)
            if (m_valid[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
         slot = best;
      end
`else
      best = 0;
`endif
      if (slot < 0) e.drop = 1'b1;
      else begin
         e.wr  = 1'b1;
         e.sel = slot;
         if (on) begin
            m_valid[slot] = 1'b1; m_note[slot] = note; m_wav[slot] = wav;
            m_seq[slot] = seq_ctr; seq_ctr++;
            e.wav = wav; e.freq = hz(note);
         end else begin
            m_valid[slot] = 1'b0;
            e.wav = m_wav[slot]; e.freq = 0;
         end
      end
      for (int i = 0; i < 64; i++) e.active[i] = m_valid[i];
   endtask

   // ---------------- DUT driving / observation ----------------
   typedef struct {
      int          n_ws, n_tf, n_drop;
      int          ws_sel, ws_wav, ws_k, tf_sel, tf_freq, tf_k, sel66;
      bit          rdy_end, timeout;
      logic [63:0] act;
   } obs_t;

   task automatic run_cmd(input bit on, input int note, input int wav, output obs_t o);
      int w;
      o = '{default: 0};
      w = 0;
      while (!cmd_ready && w < 400) begin tick(); w++; end
      if (!cmd_ready) begin o.timeout = 1'b1; return; end
      cmd_valid = 1'b1; cmd_on = on; cmd_note = 7'(note); cmd_wav = 8'(wav);
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 69; k++) begin
         if (k > 1) tick();
         if (ws_valid) begin o.n_ws++; o.ws_sel = int'(osc_sel); o.ws_wav = int'(wav_sel); o.ws_k = k; end
         if (tf_valid) begin o.n_tf++; o.tf_sel = int'(osc_sel); o.tf_freq = int'(t_freq); o.tf_k = k; end
         if (drop) o.n_drop++;
         if (k == 66) o.sel66 = int'(osc_sel);
      end
      o.rdy_end = cmd_ready;
      o.act     = active;
   endtask

   task automatic check_cmd(input string tag, input obs_t o, input bit wr, input int sel,
                            input int wav, input int freq, input logic [63:0] act);
      chk({tag, " timeout"}, longint'(o.timeout), 0);
      if (wr) begin
         chk({tag, " ws_cnt"}, o.n_ws, 1);
         chk({tag, " tf_cnt"}, o.n_tf, 1);
         chk({tag, " drop"}, o.n_drop, 0);
         chk({tag, " w0_sel"}, o.sel66, sel);
         chk({tag, " ws_sel"}, o.ws_sel, sel);
         chk({tag, " tf_sel"}, o.tf_sel, sel);
         chk({tag, " wav"}, o.ws_wav, wav);
         chk({tag, " freq"}, o.tf_freq, freq);
         chk({tag, " ws_cycle"}, o.ws_k, 67);
         chk({tag, " tf_cycle"}, o.tf_k, 68);
      end else begin
         chk({tag, " drop"}, o.n_drop, 1);
         chk({tag, " ws_cnt"}, o.n_ws, 0);
         chk({tag, " tf_cnt"}, o.n_tf, 0);
      end
      chk({tag, " active"}, longint'(o.act), longint'(act));
      chk({tag, " ready_after"}, longint'(o.rdy_end), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " ready"}, longint'(cmd_ready), 0);
      chk({tag, " sel"}, longint'(osc_sel), 0);
      chk({tag, " freq_wav"}, longint'({t_freq, wav_sel}), 0);
      chk({tag, " pulses"}, longint'({tf_valid, ws_valid, drop}), 0);
      chk({tag, " active"}, longint'(active), 0);
   endtask

   // Called with reset just released, before the first clock edge of INIT.
   task automatic check_init(input string tag);
      int bad, nws, ntf;
      bad = 0; nws = 0; ntf = 0;
      for (int c = 0; c < 192; c++) begin
         if (c > 0) tick();
         if (osc_sel !== 6'(c / 3) || ws_valid !== (c % 3 == 1) || tf_valid !== (c % 3 == 2) ||
             cmd_ready !== 1'b0 || wav_sel !== 8'd0 || t_freq !== 24'd0)
            bad++;
         if (ws_valid) nws++;
         if (tf_valid) ntf++;
      end
      tick();
      chk({tag, " seq_bad_cycles"}, bad, 0);
      chk({tag, " ws_count"}, nws, 64);
      chk({tag, " tf_count"}, ntf, 64);
      chk({tag, " ready_at_192"}, longint'(cmd_ready), 1);
      chk({tag, " active"}, longint'(active), 0);
   endtask

   typedef struct {
      bit          on;
      int          note, wav;
      bit          wr;
      int          sel, ewav, freq;
      logic [63:0] act;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      obs_t o;
      bit   on;
      int   note, wav, w;

      vecs[0] = '{1'b1, 69, 3, 1'b1, 0, 3, 440, 64'h1};
      vecs[1] = '{1'b1, 60, 1, 1'b1, 1, 1, 262, 64'h3};
      vecs[2] = '{1'b0, 69, 0, 1'b1, 0, 3, 0,   64'h2};
      vecs[3] = '{1'b0, 69, 0, 1'b0, 0, 0, 0,   64'h2};
      vecs[4] = '{1'b1, 60, 2, 1'b1, 1, 2, 262, 64'h2};

      repeat (3) tick();
      check_reset_vals("reset");
      rst_n = 1'b1;
      check_init("init");
      model_reset();

      for (int i = 0; i < 5; i++) begin
         model_cmd(vecs[i].on, vecs[i].note, vecs[i].wav, e);
         run_cmd(vecs[i].on, vecs[i].note, vecs[i].wav, o);
         check_cmd($sformatf("vec%0d", i), o, vecs[i].wr, vecs[i].sel, vecs[i].ewav,
                   vecs[i].freq, vecs[i].act);
      end

      for (int i = 0; i < 30; i++) begin
         on   = ($urandom_range(0, 9) < 6);
         note = 40 + $urandom_range(0, 5);
         wav  = $urandom_range(0, 255);
         model_cmd(on, note, wav, e);
         run_cmd(on, note, wav, o);
         check_cmd($sformatf("rnd%0d", i), o, e.wr, e.sel, e.wav, e.freq, e.active);
      end

      // Reset 20 cycles into a scan.
      w = 0;
      while (!cmd_ready && w < 400) begin tick(); w++; end
      chk("midreset ready_wait", longint'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_on = 1'b1; cmd_note = 7'd50; cmd_wav = 8'd7;
      tick();
      cmd_valid = 1'b0;
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      tick();
      tick();
      rst_n = 1'b1;
      check_init("reinit");
      model_reset();

      for (int n = 0; n < 64; n++) begin
         model_cmd(1'b1, n, n, e);
         run_cmd(1'b1, n, n, o);
         check_cmd($sformatf("fill%0d", n), o, e.wr, e.sel, e.wav, e.freq, e.active);
      end
      model_cmd(1'b1, 100, 5, e);
      run_cmd(1'b1, 100, 5, o);
      check_cmd("full", o, e.wr, e.sel, e.wav, e.freq, e.active);
`ifdef VOICE_STEAL_EN
      chk("steal sel", o.tf_sel, 0);
      chk("steal freq", o.tf_freq, 2637);
`else
      chk("full drop", o.n_drop, 1);
      chk("full no_tf", o.n_tf, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
